// File: rtl/fp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_pkg                                                               |
// | FP16/FP32 format constants, accumulator FSM state, FP16->FP32 widen. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fp_pkg;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int FP16_BIAS  = 15;
    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP32_BIAS  = 127;

    localparam logic [FP16_EXP_W-1:0] FP16_EXP_MAX = 5'h1F;
    localparam logic [FP32_EXP_W-1:0] FP32_EXP_MAX = 8'hFF;
    localparam logic [31:0]           FP32_QNAN    = 32'h7FC0_0000;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_OUT   = 1'b1
    } accum_state_t;

    // Exact widening: FP16 subnormals are renormalised, never flushed.
    function automatic logic [31:0] fp16_to_fp32(input logic [15:0] h);
        logic                  s;
        logic [FP16_EXP_W-1:0] e;
        logic [FP16_MAN_W-1:0] m;
        logic [FP32_MAN_W-1:0] f;
        logic [31:0]           r;
        int                    k;
        s = h[15];
        e = h[14:10];
        m = h[9:0];
        f = '0;
        k = 0;
        r = {s, 31'b0};
        if (e == FP16_EXP_MAX) begin
            r = (m == '0) ? {s, FP32_EXP_MAX, 23'b0} : FP32_QNAN;
        end else if (e != '0) begin
            r = {s, 8'(e) + 8'd112, m, 13'b0};
        end else if (m != '0) begin
            for (int i = 0; i < FP16_MAN_W; i++) begin
                if (m[i]) k = i;
            end
            // Leading one falls off the top of the 23-bit field.
            f = {13'b0, m} << (23 - k);
            r = {s, 8'(k + 103), f};
        end
        return r;
    endfunction
endpackage
`default_nettype wire

// File: rtl/fp32_add_rne.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp32_add_rne                                                         |
// | Combinational FP32 adder, round-to-nearest-even, optional FTZ output.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fp32_add_rne
    import fp_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        ftz_i,
    output logic [31:0] sum_o
);
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_big;
    logic [31:0] w_big, w_sml;
    logic [7:0]  w_ex_l, w_ex_s, w_d;
    logic [23:0] w_m_l, w_m_s, w_mant;
    logic [50:0] w_ext_l, w_ext_s, w_al, w_sum, w_n;
    logic        w_sticky, w_rnd;
    logic [5:0]  w_p, w_lz, w_shamt;
    logic [9:0]  w_e_res, w_exp_f;
    logic [24:0] w_mr;

    assign w_a_nan = (a_i[30:23] == FP32_EXP_MAX) && (a_i[22:0] != '0);
    assign w_b_nan = (b_i[30:23] == FP32_EXP_MAX) && (b_i[22:0] != '0);
    assign w_a_inf = (a_i[30:23] == FP32_EXP_MAX) && (a_i[22:0] == '0);
    assign w_b_inf = (b_i[30:23] == FP32_EXP_MAX) && (b_i[22:0] == '0);
    assign w_a_big = a_i[30:0] >= b_i[30:0];

    always_comb begin
        w_big   = w_a_big ? a_i : b_i;
        w_sml   = w_a_big ? b_i : a_i;
        w_ex_l  = (w_big[30:23] == '0) ? 8'd1 : w_big[30:23];
        w_ex_s  = (w_sml[30:23] == '0) ? 8'd1 : w_sml[30:23];
        w_m_l   = {w_big[30:23] != '0, w_big[22:0]};
        w_m_s   = {w_sml[30:23] != '0, w_sml[22:0]};
        w_d     = w_ex_l - w_ex_s;
        w_ext_l = {1'b0, w_m_l, 26'b0};
        w_ext_s = {1'b0, w_m_s, 26'b0};
        // 26 extra low bits keep alignment exact; anything further is jammed into bit 0.
        if (w_d > 8'd50) begin
            w_al     = '0;
            w_sticky = |w_m_s;
        end else begin
            w_al     = w_ext_s >> w_d;
            w_sticky = |(w_ext_s & ~({51{1'b1}} << w_d));
        end
        w_al[0] = w_al[0] | w_sticky;
        w_sum   = (w_big[31] ^ w_sml[31]) ? (w_ext_l - w_al) : (w_ext_l + w_al);

        w_p = '0;
        for (int i = 0; i < 51; i++) begin
            if (w_sum[i]) w_p = 6'(i);
        end
        w_lz = 6'd50 - w_p;
        // Normalisation is capped so the exponent never drops below 1 (subnormal result).
        if (({2'b0, w_ex_l} + 10'd1) > {4'b0, w_lz}) begin
            w_shamt = w_lz;
            w_e_res = {2'b0, w_ex_l} + 10'd1 - {4'b0, w_lz};
        end else begin
            w_shamt = w_ex_l[5:0];
            w_e_res = '0;
        end
        w_n     = w_sum << w_shamt;
        w_mant  = w_n[50:27];
        w_rnd   = w_n[26] & ((|w_n[25:0]) | w_mant[0]);
        w_mr    = {1'b0, w_mant} + {24'b0, w_rnd};
        w_exp_f = w_e_res + {9'b0, w_mr[24]} + {9'b0, (w_e_res == '0) && w_mr[23]};

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a_i[31] != b_i[31]))) begin
            sum_o = FP32_QNAN;
        end else if (w_a_inf) begin
            sum_o = a_i;
        end else if (w_b_inf) begin
            sum_o = b_i;
        end else if (w_sum == '0) begin
            sum_o = {a_i[31] & b_i[31], 31'b0};
        end else if (w_exp_f >= 10'd255) begin
            sum_o = {w_big[31], FP32_EXP_MAX, 23'b0};
        end else if ((w_exp_f == '0) && ftz_i) begin
            sum_o = {w_big[31], 31'b0};
        end else begin
            sum_o = {w_big[31], w_exp_f[7:0], w_mr[22:0]};
        end
    end
endmodule
`default_nettype wire

// File: rtl/fp16_prod_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp16_prod_accum                                                      |
// | Widens an FP16 product stream to FP32 and emits per-vector sums.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fp16_prod_accum
    import fp_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter bit FTZ_OUT = 1'b1
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tlast,
    output logic             m_axis_result_tvalid,
    input  logic             m_axis_result_tready,
    output logic [31:0]      m_axis_result_tdata,
    output logic [CNT_W-1:0] m_axis_result_tuser
);
    accum_state_t     state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [CNT_W-1:0] res_user_q, res_user_d;

    logic [31:0]      w_x, w_acc_op, w_sum;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_unused_hi;

    assign w_unused_hi = ^s_axis_tdata[31:16];
    assign w_x         = fp16_to_fp32(s_axis_tdata[15:0]);
    // -0 is the additive identity, so the first term (even -0) passes through unchanged.
    assign w_acc_op    = (cnt_q == '0) ? {1'b1, 31'b0} : acc_q;
    assign w_cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    fp32_add_rne u_add (
        .a_i   (w_acc_op),
        .b_i   (w_x),
        .ftz_i (FTZ_OUT),
        .sum_o (w_sum)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_user_d = res_user_q;
        case (state_q)
            ST_ACCUM: begin
                if (s_axis_tvalid) begin
                    if (s_axis_tlast) begin
                        res_data_d = w_sum;
                        res_user_d = w_cnt_inc;
                        state_d    = ST_OUT;
                    end else begin
                        acc_d = w_sum;
                        cnt_d = w_cnt_inc;
                    end
                end
            end
            ST_OUT: begin
                if (m_axis_result_tready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_user_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_user_q <= res_user_d;
        end
    end

    assign s_axis_tready        = (state_q == ST_ACCUM);
    assign m_axis_result_tvalid = (state_q == ST_OUT);
    assign m_axis_result_tdata  = res_data_q;
    assign m_axis_result_tuser  = res_user_q;
endmodule
`default_nettype wire

// File: tb/tb_fp16_prod_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fp16_prod_accum                                                   |
// | Scoreboard bench: expected {tuser,tdata} queued as last beats go in. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fp16_prod_accum;
    localparam int CNT_W = 16;

    logic             aclk = 1'b0;
    logic             areset = 1'b1;
    logic             s_tvalid = 1'b0;
    logic             s_tready;
    logic [31:0]      s_tdata = '0;
    logic             s_tlast = 1'b0;
    logic             m_tvalid;
    logic             m_tready = 1'b1;
    logic [31:0]      m_tdata;
    logic [CNT_W-1:0] m_tuser;

    int tests = 0;
    int fails = 0;
    logic [47:0] sb[$];

    fp16_prod_accum #(.CNT_W(CNT_W), .FTZ_OUT(1'b1)) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .s_axis_tvalid        (s_tvalid),
        .s_axis_tready        (s_tready),
        .s_axis_tdata         (s_tdata),
        .s_axis_tlast         (s_tlast),
        .m_axis_result_tvalid (m_tvalid),
        .m_axis_result_tready (m_tready),
        .m_axis_result_tdata  (m_tdata),
        .m_axis_result_tuser  (m_tuser)
    );

    always #5 aclk = ~aclk;

    // Called at a negedge; returns at the negedge after the beat was taken.
    task automatic send_beat(input logic [15:0] h, input logic last);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = {16'hA5A5, h};
        s_tlast  = last;
        while (!s_tready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!s_tready) begin
            tests++;
            fails++;
            $display("FAIL send_beat_timeout: s_axis_tready=%b required 1", s_tready);
        end
        @(negedge aclk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if ({m_tvalid, m_tuser, m_tdata} !== 49'd0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b user=%h data=%h required 0/0000/00000000", m_tvalid, m_tuser, m_tdata);
        end
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        tests++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got tready=%b tvalid=%b required 1/0", s_tready, m_tvalid);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] beats [13] = '{16'h3C00, 16'h4000, 16'h4200, 16'h3C00, 16'hBC00, 16'h8000,
                                    16'h7C00, 16'hFC00, 16'h7E01, 16'h7C00, 16'h0001, 16'h3C00, 16'h0001};
        logic        lasts [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                                    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [47:0] exps  [8]  = '{{16'd3, 32'h40C00000}, {16'd2, 32'h00000000}, {16'd1, 32'h80000000},
                                    {16'd2, 32'h7FC00000}, {16'd1, 32'h7FC00000}, {16'd1, 32'h7F800000},
                                    {16'd1, 32'h33800000}, {16'd2, 32'h3F800000}};
        logic [47:0] e;
        int k;
        k = 0;
        for (int i = 0; i < 13; i++) begin
            if (lasts[i]) begin
                sb.push_back(exps[k]);
                k++;
            end
            send_beat(beats[i], lasts[i]);
            if (lasts[i]) begin
                e = sb.pop_front();
                tests++;
                if (m_tvalid !== 1'b1) begin
                    fails++;
                    $display("FAIL vec%0d_latency: tvalid=%b required 1", k, m_tvalid);
                end
                tests++;
                if ({m_tuser, m_tdata} !== e) begin
                    fails++;
                    $display("FAIL vec%0d_result: got user=%0d data=%h required user=%0d data=%h",
                             k, m_tuser, m_tdata, e[47:32], e[31:0]);
                end
                @(negedge aclk);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] e;
        m_tready = 1'b0;
        sb.push_back({16'd1, 32'h40000000});
        send_beat(16'h4000, 1'b1);
        e = sb.pop_front();
        s_tvalid = 1'b1;
        s_tdata  = 32'h0000_4400;
        s_tlast  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tests++;
            if ({m_tuser, m_tdata} !== e || m_tvalid !== 1'b1 || s_tready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: got valid=%b sready=%b user=%0d data=%h required 1/0/%0d/%h",
                         c, m_tvalid, s_tready, m_tuser, m_tdata, e[47:32], e[31:0]);
            end
            @(negedge aclk);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        @(negedge aclk);
        tests++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got tvalid=%b sready=%b required 0/1", m_tvalid, s_tready);
        end
        sb.push_back({16'd1, 32'h3F800000});
        send_beat(16'h3C00, 1'b1);
        e = sb.pop_front();
        tests++;
        if ({m_tvalid, m_tuser, m_tdata} !== {1'b1, e}) begin
            fails++;
            $display("FAIL bp_next: got valid=%b user=%0d data=%h required 1/%0d/%h",
                     m_tvalid, m_tuser, m_tdata, e[47:32], e[31:0]);
        end
        @(negedge aclk);
    endtask

    task automatic test_reset_mid();
        logic [47:0] e;
        send_beat(16'h3C00, 1'b0);
        send_beat(16'h4000, 1'b0);
        #2 areset = 1'b1;
        #1;
        tests++;
        if ({s_tready, m_tvalid, m_tuser, m_tdata} !== {1'b1, 49'd0}) begin
            fails++;
            $display("FAIL rst_vec_outputs: got sready=%b valid=%b user=%0d data=%h required 1/0/0/0",
                     s_tready, m_tvalid, m_tuser, m_tdata);
        end
        @(negedge aclk);
        areset = 1'b0;
        sb.push_back({16'd1, 32'h3F800000});
        send_beat(16'h3C00, 1'b1);
        e = sb.pop_front();
        tests++;
        if ({m_tuser, m_tdata} !== e) begin
            fails++;
            $display("FAIL rst_vec_result: got user=%0d data=%h required %0d/%h", m_tuser, m_tdata, e[47:32], e[31:0]);
        end
        @(negedge aclk);
        m_tready = 1'b0;
        send_beat(16'h4000, 1'b1);
        #2 areset = 1'b1;
        #1;
        tests++;
        if ({s_tready, m_tvalid, m_tuser, m_tdata} !== {1'b1, 49'd0}) begin
            fails++;
            $display("FAIL rst_out_outputs: got sready=%b valid=%b user=%0d data=%h required 1/0/0/0",
                     s_tready, m_tvalid, m_tuser, m_tdata);
        end
        @(negedge aclk);
        areset   = 1'b0;
        m_tready = 1'b1;
        sb.push_back({16'd2, 32'h40000000});
        send_beat(16'h3C00, 1'b0);
        send_beat(16'h3C00, 1'b1);
        e = sb.pop_front();
        tests++;
        if ({m_tvalid, m_tuser, m_tdata} !== {1'b1, e}) begin
            fails++;
            $display("FAIL rst_out_next: got valid=%b user=%0d data=%h required 1/%0d/%h",
                     m_tvalid, m_tuser, m_tdata, e[47:32], e[31:0]);
        end
        @(negedge aclk);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
